// File: rtl/fifo_lifo_sync.sv
// Single-clock FIFO/LIFO buffer with run-time mode, occupancy count, programmable
// almost-full/almost-empty thresholds, sticky error flags, flush and registered read port.
module fifo_lifo_sync #(
    parameter int SIZE     = 8,
    parameter int DEPTH    = 8,
    parameter int ADR_SIZE = 3
) (
    input  logic                Clk,
    input  logic                RST_n,
    input  logic                Mode,
    input  logic                Flush,
    input  logic                Wr_En_in,
    input  logic [SIZE-1:0]     Data_in,
    input  logic                Rd_En_in,
    input  logic [ADR_SIZE:0]   AF_level,
    input  logic [ADR_SIZE:0]   AE_level,
    output logic [SIZE-1:0]     Data_out,
    output logic                Data_valid,
    output logic                Full,
    output logic                Empty,
    output logic                Almost_full,
    output logic                Almost_empty,
    output logic [ADR_SIZE:0]   Count,
    output logic                Overflow,
    output logic                Underflow
);

    localparam logic [ADR_SIZE:0]   CNT_MAX  = (ADR_SIZE+1)'(DEPTH);
    localparam logic [ADR_SIZE:0]   CNT_ONE  = (ADR_SIZE+1)'(1);
    localparam logic [ADR_SIZE-1:0] PTR_ONE  = ADR_SIZE'(1);
    localparam logic [ADR_SIZE-1:0] PTR_LAST = ADR_SIZE'(DEPTH - 1);

    logic [SIZE-1:0]     mem [DEPTH];
    logic                lifo_r;
    logic [ADR_SIZE:0]   count_r;
    logic [ADR_SIZE-1:0] wr_ptr_r;
    logic [ADR_SIZE-1:0] rd_ptr_r;
    logic                ovf_r;
    logic                unf_r;
    logic [SIZE-1:0]     rd_data_p1;
    logic                vld_p1;

    logic                wr_acc_p0;
    logic                rd_acc_p0;
    logic [ADR_SIZE-1:0] top_p0;
    logic [ADR_SIZE-1:0] wr_idx_p0;
    logic [ADR_SIZE-1:0] rd_idx_p0;

    // Pointer advance with explicit wrap so non-power-of-2 depths work.
    function automatic logic [ADR_SIZE-1:0] ptr_next(input logic [ADR_SIZE-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // Occupancy update; callers only pass accepted operations, so it stays in 0..DEPTH.
    function automatic logic [ADR_SIZE:0] count_next(input logic [ADR_SIZE:0] c,
                                                     input logic w, input logic r);
        if (w && !r) return c + CNT_ONE;
        if (r && !w) return c - CNT_ONE;
        return c;
    endfunction

    // ---- stage p0: request qualification and addressing ----
    assign Full         = (count_r == CNT_MAX);
    assign Empty        = (count_r == '0);
    assign Almost_full  = (count_r >= AF_level);
    assign Almost_empty = (count_r <= AE_level);

    assign wr_acc_p0 = Wr_En_in & ~Full;
    assign rd_acc_p0 = Rd_En_in & ~Empty;

    // Stack top is Count-1; low bits alone suffice because Count never exceeds DEPTH.
    assign top_p0    = count_r[ADR_SIZE-1:0] - PTR_ONE;
    assign wr_idx_p0 = lifo_r ? (rd_acc_p0 ? top_p0 : count_r[ADR_SIZE-1:0]) : wr_ptr_r;
    assign rd_idx_p0 = lifo_r ? top_p0 : rd_ptr_r;

    always_ff @(posedge Clk) begin
        if (RST_n && !Flush && wr_acc_p0)
            mem[wr_idx_p0] <= Data_in;
    end

    // ---- stage p1: registered state and read port ----
    always_ff @(posedge Clk) begin
        if (!RST_n) begin
            lifo_r     <= Mode;
            count_r    <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
            vld_p1     <= 1'b0;
            rd_data_p1 <= '0;
        end else if (Flush) begin
            lifo_r     <= Mode;
            count_r    <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
            vld_p1     <= 1'b0;
        end else begin
            count_r <= count_next(count_r, wr_acc_p0, rd_acc_p0);
            if (!lifo_r && wr_acc_p0)
                wr_ptr_r <= ptr_next(wr_ptr_r);
            if (!lifo_r && rd_acc_p0)
                rd_ptr_r <= ptr_next(rd_ptr_r);
            if (Wr_En_in && Full)
                ovf_r <= 1'b1;
            if (Rd_En_in && Empty)
                unf_r <= 1'b1;
            vld_p1 <= rd_acc_p0;
            if (rd_acc_p0)
                rd_data_p1 <= mem[rd_idx_p0];
        end
    end

    assign Data_out   = rd_data_p1;
    assign Data_valid = vld_p1;
    assign Count      = count_r;
    assign Overflow   = ovf_r;
    assign Underflow  = unf_r;

endmodule

// File: tb/tb_fifo_lifo_sync.sv
// Directed bench for fifo_lifo_sync: FIFO/LIFO ordering, simultaneous access,
// error flags, thresholds, mode latching, flush and reset.
module tb_fifo_lifo_sync;

    logic       Clk;
    logic       RST_n;
    logic       Mode;
    logic       Flush;
    logic       Wr_En_in;
    logic [7:0] Data_in;
    logic       Rd_En_in;
    logic [3:0] AF_level;
    logic [3:0] AE_level;
    logic [7:0] Data_out;
    logic       Data_valid;
    logic       Full;
    logic       Empty;
    logic       Almost_full;
    logic       Almost_empty;
    logic [3:0] Count;
    logic       Overflow;
    logic       Underflow;

    int errors = 0;
    int checks = 0;

    fifo_lifo_sync #(.SIZE(8), .DEPTH(8), .ADR_SIZE(3)) dut (
        .Clk(Clk), .RST_n(RST_n), .Mode(Mode), .Flush(Flush),
        .Wr_En_in(Wr_En_in), .Data_in(Data_in), .Rd_En_in(Rd_En_in),
        .AF_level(AF_level), .AE_level(AE_level),
        .Data_out(Data_out), .Data_valid(Data_valid),
        .Full(Full), .Empty(Empty),
        .Almost_full(Almost_full), .Almost_empty(Almost_empty),
        .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        Wr_En_in = 1'b1; Data_in = d;
        tick();
        Wr_En_in = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        Rd_En_in = 1'b1;
        tick();
        Rd_En_in = 1'b0;
        chk({tag, "_valid"}, Data_valid, 1);
        chk({tag, "_data"}, Data_out, exp);
    endtask

    task automatic do_flush(input logic m);
        Mode = m; Flush = 1'b1;
        tick();
        Flush = 1'b0;
    endtask

    initial begin
        // Reset with a write request pending: write must be ignored
        RST_n = 1'b0; Mode = 1'b0; Flush = 1'b0; Wr_En_in = 1'b1; Data_in = 8'hEE;
        Rd_En_in = 1'b0; AF_level = 4'd6; AE_level = 4'd2;
        tick();
        chk("rst_count", Count, 0);
        chk("rst_empty", Empty, 1);
        chk("rst_full", Full, 0);
        chk("rst_dout", Data_out, 0);
        chk("rst_valid", Data_valid, 0);
        chk("rst_ae", Almost_empty, 1);
        chk("rst_af", Almost_full, 0);
        chk("rst_ovf", Overflow, 0);
        chk("rst_unf", Underflow, 0);
        RST_n = 1'b1; Wr_En_in = 1'b0;
        tick();
        chk("rst_count_hold", Count, 0);

        // FIFO wrap
        for (int i = 1; i <= 8; i++) push(8'(i));
        chk("t1_full", Full, 1);
        chk("t1_count8", Count, 8);
        for (int i = 1; i <= 4; i++) pop_chk("t1_popa", 8'(i));
        tick();
        chk("t1_valid_drop", Data_valid, 0);
        chk("t1_dout_hold", Data_out, 8'h04);
        chk("t1_count4", Count, 4);
        for (int i = 9; i <= 12; i++) push(8'(i));
        chk("t1_count8b", Count, 8);
        for (int i = 5; i <= 12; i++) pop_chk("t1_popb", 8'(i));
        chk("t1_empty", Empty, 1);
        chk("t1_ovf_clear", Overflow, 0);

        // Overflow with threshold tracking
        chk("t5_ae_c0", Almost_empty, 1);
        for (int i = 1; i <= 9; i++) begin
            push(8'(8'h30 + i));
            if (i <= 8) begin
                chk("t5_ae", Almost_empty, (i <= 2) ? 1 : 0);
                chk("t5_af", Almost_full, (i >= 6) ? 1 : 0);
            end
        end
        chk("t4_ovf", Overflow, 1);
        chk("t4_count", Count, 8);
        for (int i = 1; i <= 8; i++) pop_chk("t4_drain", 8'(8'h30 + i));
        chk("t4_unf_before", Underflow, 0);
        Rd_En_in = 1'b1;
        tick();
        Rd_En_in = 1'b0;
        chk("t4_extra_valid", Data_valid, 0);
        chk("t4_unf", Underflow, 1);
        chk("t4_extra_hold", Data_out, 8'h38);
        Wr_En_in = 1'b1; Data_in = 8'hDD;
        do_flush(1'b0);
        Wr_En_in = 1'b0;
        chk("t4_flush_ovf", Overflow, 0);
        chk("t4_flush_unf", Underflow, 0);
        chk("t4_flush_count", Count, 0);
        chk("t4_flush_dout", Data_out, 8'h38);

        // FIFO: read with first write to empty, then simultaneous at Count=1
        Wr_En_in = 1'b1; Rd_En_in = 1'b1; Data_in = 8'h20;
        tick();
        chk("t3_first_valid", Data_valid, 0);
        chk("t3_first_unf", Underflow, 1);
        chk("t3_first_count", Count, 1);
        Data_in = 8'h21;
        tick();
        Wr_En_in = 1'b0; Rd_En_in = 1'b0;
        chk("t3_fifo_rw_data", Data_out, 8'h20);
        chk("t3_fifo_rw_valid", Data_valid, 1);
        chk("t3_fifo_rw_count", Count, 1);
        pop_chk("t3_fifo_next", 8'h21);
        do_flush(1'b0);

        // Mode change ignored outside flush/reset
        push(8'h41); push(8'h42); push(8'h43);
        Mode = 1'b1;
        pop_chk("t6_mode_ign", 8'h41);
        pop_chk("t6_mode_ign", 8'h42);
        pop_chk("t6_mode_ign", 8'h43);
        do_flush(1'b1);

        // LIFO order
        push(8'hA0); push(8'hA1); push(8'hA2);
        pop_chk("t2_lifo", 8'hA2);
        pop_chk("t2_lifo", 8'hA1);
        pop_chk("t2_lifo", 8'hA0);
        chk("t2_empty", Empty, 1);
        chk("t2_count", Count, 0);

        // LIFO simultaneous read+write replaces top
        push(8'h10); push(8'h11);
        Wr_En_in = 1'b1; Rd_En_in = 1'b1; Data_in = 8'h55;
        tick();
        Wr_En_in = 1'b0; Rd_En_in = 1'b0;
        chk("t3_lifo_rw_data", Data_out, 8'h11);
        chk("t3_lifo_rw_valid", Data_valid, 1);
        chk("t3_lifo_rw_count", Count, 2);
        pop_chk("t3_lifo_next", 8'h55);
        pop_chk("t3_lifo_last", 8'h10);

        // Reset mid-contents with write pending, Mode back to FIFO, AF_level=0
        push(8'h61); push(8'h62);
        RST_n = 1'b0; Wr_En_in = 1'b1; Data_in = 8'h77; Mode = 1'b0; AF_level = 4'd0;
        tick();
        chk("t6_rst_count", Count, 0);
        chk("t6_rst_empty", Empty, 1);
        chk("t6_rst_dout", Data_out, 0);
        chk("t6_rst_valid", Data_valid, 0);
        chk("t6_rst_af", Almost_full, 1);
        chk("t6_rst_ovf", Overflow, 0);
        RST_n = 1'b1; Wr_En_in = 1'b0; AF_level = 4'd6;
        push(8'h71); push(8'h72);
        pop_chk("t6_fifo_again", 8'h71);
        pop_chk("t6_fifo_again", 8'h72);
        chk("t6_final_empty", Empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_lifo_sync.md
# fifo_lifo_sync

Single-clock, parametrised FIFO/LIFO buffer with run-time mode select, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, flush, and a registered read port with a valid strobe. It is the single-clock-domain generation of the team's dual-mode buffer. It sits between producer and consumer logic sharing one clock and adds defined simultaneous read/write behaviour in both modes.

## Interface
- SIZE, 8, data word width in bits
- DEPTH, 8, number of storage words; 2 ≤ DEPTH ≤ 2**ADR_SIZE
- ADR_SIZE, 3, address width; Count and level inputs are ADR_SIZE+1 bits wide
- Clk  input  1  single clock; all logic on rising edge
- RST_n  input  1  reset, synchronous, active-low
- Mode  input  1  0 = FIFO, 1 = LIFO; latched only during reset or Flush
- Flush  input  1  synchronous clear of contents and sticky flags
- Wr_En_in  input  1  write request
- Data_in  input  SIZE  write data
- Rd_En_in  input  1  read request
- AF_level  input  ADR_SIZE+1  almost-full threshold
- AE_level  input  ADR_SIZE+1  almost-empty threshold
- Data_out  output  SIZE  registered read data
- Data_valid  output  1  high for one cycle when Data_out carries newly read data
- Full, Empty  output  1  Count == DEPTH / Count == 0
- Almost_full, Almost_empty  output  1  Count ≥ AF_level / Count ≤ AE_level
- Count  output  ADR_SIZE+1  current occupancy, 0..DEPTH
- Overflow, Underflow  output  1  sticky error flags

## Operation
- Internal mode register: loads Mode when RST_n = 0 or Flush = 1; holds otherwise. Mode changes at other times are ignored.
- Write is accepted when Wr_En_in & ~Full. Read is accepted when Rd_En_in & ~Empty. Full and Empty come from the registered Count of the current cycle.
- Overflow sets on Wr_En_in & Full. Underflow sets on Rd_En_in & Empty. Both stay set until reset or Flush.
- FIFO mode: write to mem[wr_ptr], read from mem[rd_ptr]. Each pointer increments on acceptance and wraps from DEPTH-1 to 0, including non-power-of-2 DEPTH.
- LIFO mode: top index = Count-1.
  - Write-only: store at mem[Count], Count+1.
  - Read-only: output mem[Count-1], Count-1.
  - Read and write both accepted: output mem[Count-1] (old top), overwrite mem[Count-1] with Data_in, Count unchanged.
- FIFO mode, read and write both accepted: both pointers advance, Count unchanged. This includes the case Count = 1: the old word is read out and the new word is stored.
- Count: +1 on write-only, -1 on read-only, unchanged on both or neither. It never exceeds DEPTH and never underflows.
- Priority, highest first:
  1. RST_n low
  2. Flush
  3. Wr/Rd
- Flush clears Count and both pointers to 0, clears Overflow, Underflow and Data_valid, holds Data_out, and ignores any Wr/Rd in the same cycle. Memory contents need no clearing.
- Almost_full and Almost_empty are combinational compares of registered Count against the live level inputs.

## Timing
- Read latency is 1 cycle. On the cycle after an accepted read, Data_out holds the word and Data_valid = 1.
- Data_valid is 0 in every cycle not following an accepted read. Data_out holds its last value when no read is accepted.
- Count, Full, Empty, pointers and sticky flags update on the edge that accepts the operation. A write to an empty buffer deasserts Empty on the next cycle.
- A read request in the same cycle as the first write to an empty buffer is rejected and sets Underflow.
- Reset values (one edge with RST_n = 0):
  - Data_out = 0, Data_valid = 0
  - Count = 0, Empty = 1, Full = 0
  - Almost_empty = 1; Almost_full = (AF_level == 0)
  - Overflow = 0, Underflow = 0; pointers = 0
- Reset asserted mid-burst discards all contents. Wr/Rd in the reset cycle are ignored and do not set sticky flags.

## Test plan
1. FIFO wrap, DEPTH=8, Mode=0: write 0x01..0x08 → Full=1, Count=8. Read 4 → 0x01..0x04, each Data_valid one cycle after its request. Write 0x09..0x0C, then read 8 → 0x05..0x0C in order, Empty=1.
2. LIFO order, Mode=1: write 0xA0, 0xA1, 0xA2, read 3 → 0xA2, 0xA1, 0xA0. Then Empty=1, Count=0.
3. Simultaneous operations:
   - LIFO holding 0x10, 0x11: read+write 0x55 → Data_out=0x11, Count stays 2; next read → 0x55.
   - FIFO holding only 0x20: read+write 0x21 → Data_out=0x20, Count=1; next read → 0x21.
4. Errors, FIFO: write 9 words at DEPTH=8 → 9th dropped, Overflow=1. Drain 8 reads plus one extra → extra gives Data_valid=0 and Underflow=1. Flush → both flags 0.
5. Thresholds, AF_level=6, AE_level=2: Almost_empty=1 for Count 0..2. Almost_full goes 1 at Count=6 and stays 1 through Count=8.
6. Mode/flush/reset:
   - Mode toggled while Count=3 → ordering unchanged. Flush with Mode=1 → LIFO behaviour from the next cycle.
   - RST_n=0 for one cycle with Wr_En_in=1 → all reset values, Count=0.
